regression_accumulator: RTL and testbench

REGRESSION_ACCUMULATOR -- requirements
Module: regression_accumulator

---
 rtl/regression_accumulator.sv | 139 +++++++++++++
 tb/tb_regression_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regression_accumulator.sv
// Accumulates sum_x, sum_y, sum_xy and sum_xx over up to MAX_PAIRS (x,y) pairs read from a sample memory.
// Latency: done pulses 3*count+1 cycles after start is accepted, or 1 cycle after when count is 0.
// Backpressure: none; start is accepted only in IDLE, and sums hold after done until the next start.
module regression_accumulator #(
    parameter int MAX_PAIRS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  n_pairs,
    output logic [5:0]  mem_addr,
    output logic        mem_wr,
    input  logic [7:0]  mem_out,
    output logic [12:0] sum_x,
    output logic [12:0] sum_y,
    output logic [20:0] sum_xy,
    output logic [20:0] sum_xx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_X,
        FETCH_Y,
        ACC,
        DONE
    } state_t;

    localparam logic [5:0] MAX_CNT = 6'(MAX_PAIRS);

    state_t      state;
    state_t      next_state;
    logic [5:0]  count_q;
    logic [4:0]  k_q;
    logic [5:0]  addr_q;
    logic [7:0]  x_q;
    logic [5:0]  n_clamped;
    logic        last_pair;
    logic [15:0] prod_xy;
    logic [15:0] prod_xx;

    // The memory is read-only from this block.
    assign mem_wr    = 1'b0;

    assign n_clamped = (n_pairs > MAX_CNT) ? MAX_CNT : n_pairs;
    assign last_pair = ({1'b0, k_q} == (count_q - 6'd1));
    assign prod_xy   = 16'(x_q) * 16'(mem_out);
    assign prod_xx   = 16'(x_q) * 16'(x_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, busy and read address; the address is held from addr_q outside the fetch states.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        mem_addr   = addr_q;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (n_clamped == 6'd0) ? DONE : FETCH_X;
                end
            end
            FETCH_X: begin
                busy       = 1'b1;
                mem_addr   = {k_q, 1'b0};
                next_state = FETCH_Y;
            end
            FETCH_Y: begin
                busy       = 1'b1;
                mem_addr   = {k_q, 1'b1};
                next_state = ACC;
            end
            ACC: begin
                busy       = 1'b1;
                next_state = last_pair ? DONE : FETCH_X;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: pair index, x capture, sums, held address and the done pulse.
    // done is registered off the DONE state, so it lands the cycle after DONE and the sums are already final.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 6'd0;
            k_q     <= 5'd0;
            addr_q  <= 6'd0;
            x_q     <= 8'd0;
            sum_x   <= 13'd0;
            sum_y   <= 13'd0;
            sum_xy  <= 21'd0;
            sum_xx  <= 21'd0;
            done    <= 1'b0;
        end else begin
            done   <= (state == DONE);
            addr_q <= mem_addr;
            case (state)
                IDLE: begin
                    if (start) begin
                        count_q <= n_clamped;
                        k_q     <= 5'd0;
                        sum_x   <= 13'd0;
                        sum_y   <= 13'd0;
                        sum_xy  <= 21'd0;
                        sum_xx  <= 21'd0;
                    end
                end
                FETCH_Y: begin
                    x_q <= mem_out;
                end
                ACC: begin
                    sum_x  <= sum_x + {5'd0, x_q};
                    sum_y  <= sum_y + {5'd0, mem_out};
                    sum_xy <= sum_xy + {5'd0, prod_xy};
                    sum_xx <= sum_xx + {5'd0, prod_xx};
                    if (!last_pair) begin
                        k_q <= k_q + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regression_accumulator.sv
// Bench for regression_accumulator: directed passes, expected sums pushed to a scoreboard.
// A monitor pops one entry per done pulse and checks sums and start-to-done latency.
// Also covers reset state, address sequence, ignored starts, clamping and mid-pass reset.
module tb_regression_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  n_pairs = 6'd0;
    logic [5:0]  mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_out = 8'd0;
    logic [12:0] sum_x;
    logic [12:0] sum_y;
    logic [20:0] sum_xy;
    logic [20:0] sum_xx;
    logic        busy;
    logic        done;

    regression_accumulator #(.MAX_PAIRS(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n_pairs (n_pairs),
        .mem_addr(mem_addr),
        .mem_wr  (mem_wr),
        .mem_out (mem_out),
        .sum_x   (sum_x),
        .sum_y   (sum_y),
        .sum_xy  (sum_xy),
        .sum_xx  (sum_xx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Sample memory with registered read.
    logic [7:0] mem [64];
    always @(posedge clk) mem_out <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sx;
        int sy;
        int sxy;
        int sxx;
        int lat;
        int acc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic wr_bad   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mem_wr !== 1'b0) wr_bad = 1'b1;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sum_x",   int'(sum_x),  e.sx);
                chk("sum_y",   int'(sum_y),  e.sy);
                chk("sum_xy",  int'(sum_xy), e.sxy);
                chk("sum_xx",  int'(sum_xx), e.sxx);
                chk("latency", cyc - e.acc,  e.lat);
            end
        end
    end

    task automatic start_pass(input int n, input bit push,
                              input int sx, input int sy, input int sxy, input int sxx, input int lat);
        exp_t e;
        @(negedge clk);
        n_pairs = 6'(n);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.sx = sx; e.sy = sy; e.sxy = sxy; e.sxx = sxx; e.lat = lat; e.acc = cyc;
        if (push) sbq.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (sbq.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", sbq.size(), 0);
        @(negedge clk);
    endtask

    task automatic load_small();
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        mem[0] = 8'd1; mem[1] = 8'd2;
        mem[2] = 8'd2; mem[3] = 8'd4;
        mem[4] = 8'd3; mem[5] = 8'd6;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   addr_exp [6];
        logic bz;

        load_small();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_sum_x",   int'(sum_x),    0);
        chk("rst_sum_xy",  int'(sum_xy),   0);
        chk("rst_busy",    int'(busy),     0);
        chk("rst_done",    int'(done),     0);
        chk("rst_addr",    int'(mem_addr), 0);
        chk("rst_mem_wr",  int'(mem_wr),   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three pairs: (1,2),(2,4),(3,6).
        start_pass(3, 1'b1, 6, 12, 28, 14, 10);
        wait_drain(50);
        repeat (5) @(negedge clk);
        chk("hold_sum_x",  int'(sum_x),  6);
        chk("hold_sum_xy", int'(sum_xy), 28);

        // Single pair.
        start_pass(1, 1'b1, 1, 2, 2, 1, 4);
        wait_drain(50);

        // Zero pairs: done one cycle later, busy never high.
        start_pass(0, 1'b1, 0, 0, 0, 0, 1);
        bz = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy === 1'b1) bz = 1'b1;
        end
        chk("n0_busy_seen", int'(bz), 0);
        wait_drain(10);

        // Two pairs: address sequence, start held high while busy and in DONE.
        addr_exp = '{0, 1, 1, 2, 3, 3};
        @(negedge clk);
        n_pairs = 6'd2;
        start   = 1'b1;
        @(posedge clk);
        #1;
        e.sx = 3; e.sy = 6; e.sxy = 10; e.sxx = 5; e.lat = 7; e.acc = cyc;
        sbq.push_back(e);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("addr_seq", int'(mem_addr), addr_exp[i]);
            chk("addr_busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("done_state_busy", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("no_restart_busy", int'(busy), 0);
        end
        wait_drain(10);

        // All 0xFF: 32 pairs, then 40 clamped to 32.
        for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
        start_pass(32, 1'b1, 8160, 8160, 2080800, 2080800, 97);
        wait_drain(200);
        start_pass(40, 1'b1, 8160, 8160, 2080800, 2080800, 97);
        wait_drain(200);

        // Reset during ACC of pair 1, then a clean pass.
        load_small();
        start_pass(3, 1'b0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_sum_x",  int'(sum_x),    0);
        chk("abort_sum_y",  int'(sum_y),    0);
        chk("abort_sum_xx", int'(sum_xx),   0);
        chk("abort_busy",   int'(busy),     0);
        chk("abort_done",   int'(done),     0);
        chk("abort_addr",   int'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        start_pass(3, 1'b1, 6, 12, 28, 14, 10);
        wait_drain(50);

        chk("mem_wr_never_high", int'(wr_bad), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
